trisc_mem: RTL
==============

# trisc_mem

Memory responder for the TRISC datapath: a 16x8 synchronous RAM with its own memory address register (MAR), driven by the control strobes that the TRISC control FSM issues during fetch, LDA, ADD (operand read) and STA (store). It enforces the FSM's two-cycle access protocol and returns read data with a one-cycle valid pulse. It flags protocol violations in a sticky error bit. A side-band program-load port lets the bench or boot logic fill memory before the processor is started.

## Interface
- ADDR_W, 4, address width (16 words)
- DATA_W, 8, data word width
- SysClock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- LdMar  in  1  load MAR from MarAddr this cycle
- MarAddr  in  ADDR_W  address source (PC or IR operand field)
- RdEn  in  1  read strobe; must be held 2 consecutive cycles
- WrEn  in  1  write strobe; must be held 2 consecutive cycles
- WrData  in  DATA_W  store data (accumulator)
- ProgWe  in  1  program-load write, direct addressing
- ProgAddr  in  ADDR_W  program-load address
- ProgData  in  DATA_W  program-load data
- RdData  out  DATA_W  last completed read word; held until the next read completes
- RdValid  out  1  one-cycle pulse when RdData updates
- WrDone  out  1  one-cycle pulse after a write commits
- Busy  out  1  high in RD1/WR1
- Err  out  1  sticky protocol error; cleared only by Reset

## Operation
- States: IDLE, RD1, RD2, WR1, WR2.
- IDLE:
  - RdEn&!WrEn -> RD1.
  - WrEn&!RdEn -> WR1.
  - RdEn&WrEn -> set Err, stay IDLE, no access.
  - LdMar: MAR <= MarAddr.
  - ProgWe: mem[ProgAddr] <= ProgData.
- RD1:
  - RdEn=1 -> RD2; RdData <= mem[MAR], RdValid=1 in RD2.
  - RdEn=0 -> abort to IDLE, set Err, RdData unchanged.
- RD2 (done state, one cycle):
  - RdEn=1 -> RD1 (back-to-back read).
  - WrEn=1 -> WR1.
  - Both strobes low -> IDLE.
  - LdMar is honoured in RD2.
- WR1:
  - WrEn=1 -> WR2; mem[MAR] <= WrData sampled this cycle; WrDone=1 in WR2.
  - WrEn=0 -> abort to IDLE, set Err, memory unchanged.
- WR2: same exits as RD2.
- Violations:
  - LdMar in RD1/WR1 is ignored and sets Err; MAR is stable through any access.
  - ProgWe outside IDLE is ignored and sets Err.
  - A RdEn or WrEn edge arriving while the other strobe is active sets Err; the in-progress access continues.
- Address wraps naturally at ADDR_W bits; no bounds error.
- Reset:
  - State -> IDLE; MAR, RdData, RdValid, WrDone, Busy, Err all 0.
  - Memory contents are NOT reset.
  - Reset mid-access aborts the access: no write commits and no RdValid pulse.

## Timing
- LdMar in cycle n -> MAR valid from cycle n+1; RdEn may first assert in cycle n+1.
- Read: RdEn high in cycles n, n+1 -> RdData/RdValid in cycle n+2 (latency 2). This matches the FSM holding the read strobe across two states.
- Write: WrEn high in cycles n, n+1 -> mem updated at edge ending n+1; WrDone in n+2. A read of the same address started in n+2 returns the new data.
- ProgWe: commits at the same edge; a read issued in the next cycle sees the new data.
- Busy is combinational from state only (Moore). RdValid and WrDone are registered.
- Back-to-back reads achieve one word per 2 cycles (RD1, RD2, RD1, ...).

## Structure
- trisc_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The state enum (IDLE, RD1, RD2, WR1, WR2).
- Sub-module trisc_ram16x8:
  - Plain storage array.
  - One synchronous write port, muxed between the access path and ProgWe.
  - One read port.
  - The control FSM, MAR and error logic stay in trisc_mem.

## Test plan
- Program-load 0xA5 at addr 3; LdMar addr 3; RdEn 2 cycles -> RdValid one cycle later with RdData=0xA5, Err=0.
- LdMar addr 7; WrEn 2 cycles with WrData=0x3C; then read addr 7 -> WrDone pulse; read returns 0x3C.
- Read held 4 cycles at addr 3 then addr 4 (0x11) with LdMar in RD2 -> two RdValid pulses, 0xA5 then 0x11.
- RdEn for 1 cycle only -> Err=1, no RdValid, RdData keeps its old value; Err stays 1 until Reset.
- RdEn&WrEn together in IDLE; also LdMar during RD1 -> Err=1, memory and MAR unchanged.
- Reset asserted in WR1 for a write of 0xFF to addr 2 (previously 0x00) -> all outputs 0 next cycle; later read of addr 2 returns 0x00.

Source files
------------

// File: rtl/trisc_pkg.sv
// trisc_pkg
//   Shared definitions for the TRISC memory responder.
//   - DEF_ADDR_W / DEF_DATA_W : default address and data widths (16 x 8 RAM)
//   - mem_state_e             : access protocol states seen by trisc_mem
package trisc_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // Two-cycle access protocol: *1 is the strobe-held cycle, *2 is the
    // one-cycle done state in which the result (RdValid / WrDone) is visible.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4
    } mem_state_e;

    // Busy covers the cycles where the access has started but not completed.
    function automatic logic state_is_busy(input mem_state_e st);
        return (st == RD1) || (st == WR1);
    endfunction

endpackage

// File: rtl/trisc_ram16x8.sv
// trisc_ram16x8
//   Plain storage array for the TRISC memory responder. No reset: contents
//   survive Reset so a loaded program is kept.
//   Ports:
//     clk        in   write clock
//     acc_we     in   access-path write enable (store from the datapath)
//     acc_addr   in   access-path write address (MAR)
//     acc_data   in   access-path write data
//     prog_we    in   program-load write enable
//     prog_addr  in   program-load write address
//     prog_data  in   program-load write data
//     raddr      in   read address
//     rdata      out  asynchronous read data at raddr
module trisc_ram16x8
    import trisc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_data,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port. The controller only enables prog_we in IDLE and
    // acc_we in WR1, so the two never collide; the access path wins anyway.
    always_ff @(posedge clk) begin
        if (acc_we) begin
            mem[acc_addr] <= acc_data;
        end else if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trisc_mem.sv
// trisc_mem
//   Memory responder for the TRISC datapath. Owns the MAR and enforces the
//   two-cycle strobe protocol of the control FSM; the storage lives in
//   trisc_ram16x8.
//   Ports:
//     SysClock  in   system clock, rising edge
//     Reset     in   synchronous active-high reset
//     LdMar     in   load MAR from MarAddr
//     MarAddr   in   MAR source (PC or IR operand)
//     RdEn      in   read strobe, held two cycles
//     WrEn      in   write strobe, held two cycles
//     WrData    in   store data
//     ProgWe    in   program-load write (IDLE only)
//     ProgAddr  in   program-load address
//     ProgData  in   program-load data
//     RdData    out  last completed read word
//     RdValid   out  one-cycle pulse when RdData updates
//     WrDone    out  one-cycle pulse after a write commits
//     Busy      out  high in RD1 / WR1
//     Err       out  sticky protocol error, cleared by Reset only
module trisc_mem
    import trisc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              SysClock,
    input  logic              Reset,
    input  logic              LdMar,
    input  logic [ADDR_W-1:0] MarAddr,
    input  logic              RdEn,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] WrData,
    input  logic              ProgWe,
    input  logic [ADDR_W-1:0] ProgAddr,
    input  logic [DATA_W-1:0] ProgData,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              WrDone,
    output logic              Busy,
    output logic              Err
);

    mem_state_e        state;
    logic [ADDR_W-1:0] mar;
    logic              rd_q;
    logic              wr_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              acc_we;
    logic              prog_we;
    logic              strobe_clash;

    // Reset gates both write enables so an access interrupted by Reset
    // never commits.
    assign acc_we  = (state == WR1) && WrEn && !Reset;
    assign prog_we = (state == IDLE) && ProgWe && !Reset;

    // One strobe rising while the other is already high is a protocol
    // violation; the access already under way is left to finish.
    assign strobe_clash = (RdEn && !rd_q && WrEn) || (WrEn && !wr_q && RdEn);

    // Moore output from state only.
    assign Busy = state_is_busy(state);

    trisc_ram16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (SysClock),
        .acc_we    (acc_we),
        .acc_addr  (mar),
        .acc_data  (WrData),
        .prog_we   (prog_we),
        .prog_addr (ProgAddr),
        .prog_data (ProgData),
        .raddr     (mar),
        .rdata     (ram_rdata)
    );

    always_ff @(posedge SysClock) begin
        if (Reset) begin
            state   <= IDLE;
            mar     <= '0;
            RdData  <= '0;
            RdValid <= 1'b0;
            WrDone  <= 1'b0;
            Err     <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            rd_q    <= RdEn;
            wr_q    <= WrEn;
            RdValid <= 1'b0;
            WrDone  <= 1'b0;

            if (strobe_clash) begin
                Err <= 1'b1;
            end

            // MAR must stay stable while an access is in its first cycle.
            if (LdMar) begin
                if (state_is_busy(state)) begin
                    Err <= 1'b1;
                end else begin
                    mar <= MarAddr;
                end
            end

            // Program loads are only legal while the bus is idle; the write
            // itself is gated by prog_we.
            if (ProgWe && (state != IDLE)) begin
                Err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (RdEn && WrEn) begin
                        Err <= 1'b1;
                    end else if (RdEn) begin
                        state <= RD1;
                    end else if (WrEn) begin
                        state <= WR1;
                    end
                end
                RD1: begin
                    if (RdEn) begin
                        RdData  <= ram_rdata;
                        RdValid <= 1'b1;
                        state   <= RD2;
                    end else begin
                        Err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                WR1: begin
                    if (WrEn) begin
                        WrDone <= 1'b1;
                        state  <= WR2;
                    end else begin
                        Err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                RD2, WR2: begin
                    // Done states: a held strobe chains straight into the
                    // next access, giving one word every two cycles.
                    if (RdEn) begin
                        state <= RD1;
                    end else if (WrEn) begin
                        state <= WR1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
